// File: rtl/vx_core_mem_bridge.sv
// Core-to-L2 memory bridge: registered request FIFO, credit-limited reads, one-entry response register.
// Latency is 1 cycle each way; core_req_ready drops when the FIFO is full, mem_rsp_ready drops while a response is held.
module vx_core_mem_bridge #(
   parameter int DATA_WIDTH  = 512,
   parameter int ADDR_WIDTH  = 26,
   parameter int TAG_WIDTH   = 8,
   parameter int REQ_DEPTH   = 4,
   parameter int MAX_PENDING = 16
) (
   input  logic                               clk,
   input  logic                               reset,

   input  logic                               core_req_valid,
   input  logic                               core_req_rw,
   input  logic [DATA_WIDTH/8-1:0]            core_req_byteen,
   input  logic [ADDR_WIDTH-1:0]              core_req_addr,
   input  logic [DATA_WIDTH-1:0]              core_req_data,
   input  logic [TAG_WIDTH-1:0]               core_req_tag,
   output logic                               core_req_ready,

   output logic                               core_rsp_valid,
   output logic [DATA_WIDTH-1:0]              core_rsp_data,
   output logic [TAG_WIDTH-1:0]               core_rsp_tag,
   input  logic                               core_rsp_ready,

   output logic                               mem_req_valid,
   output logic                               mem_req_rw,
   output logic [DATA_WIDTH/8-1:0]            mem_req_byteen,
   output logic [ADDR_WIDTH-1:0]              mem_req_addr,
   output logic [DATA_WIDTH-1:0]              mem_req_data,
   output logic [TAG_WIDTH-1:0]               mem_req_tag,
   input  logic                               mem_req_ready,

   input  logic                               mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
   input  logic [TAG_WIDTH-1:0]               mem_rsp_tag,
   output logic                               mem_rsp_ready,

   output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
   output logic                               busy,
   output logic                               rsp_err
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam int PW   = $clog2(REQ_DEPTH) + 1;
   localparam int CW   = $clog2(MAX_PENDING + 1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_PENDING);

   typedef struct packed {
      logic                  rw;
      logic [BE_W-1:0]       byteen;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [TAG_WIDTH-1:0]  tag;
   } req_t;

   req_t                  fifo_mem [REQ_DEPTH];
   req_t                  req_in;
   req_t                  head;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  out_en;
   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  rd_issue;
   logic                  rsp_take;
   logic                  rsp_deliver;
   logic                  rsp_q_valid;
   logic [DATA_WIDTH-1:0] rsp_q_data;
   logic [TAG_WIDTH-1:0]  rsp_q_tag;

   assign req_in = '{rw: core_req_rw, byteen: core_req_byteen, addr: core_req_addr,
                     data: core_req_data, tag: core_req_tag};

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign head  = fifo_mem[rd_ptr[PW-2:0]];

   // out_en holds the ready outputs low until the first edge after reset release
   assign core_req_ready = out_en && !full;
   assign push           = core_req_valid && core_req_ready;

   // A throttled read at the head stalls everything behind it to keep strict order
   assign mem_req_valid  = !empty && (head.rw || (pending_count < CREDIT_MAX));
   assign pop            = mem_req_valid && mem_req_ready;
   assign rd_issue       = pop && !head.rw;
   assign mem_req_rw     = head.rw;
   assign mem_req_byteen = head.byteen;
   assign mem_req_addr   = head.addr;
   assign mem_req_data   = head.data;
   assign mem_req_tag    = head.tag;

   assign mem_rsp_ready  = out_en && (!rsp_q_valid || core_rsp_ready);
   assign rsp_take       = mem_rsp_valid && mem_rsp_ready;
   assign core_rsp_valid = rsp_q_valid;
   assign core_rsp_data  = rsp_q_data;
   assign core_rsp_tag   = rsp_q_tag;
   assign rsp_deliver    = rsp_q_valid && core_rsp_ready;

   assign busy = !empty || (pending_count != '0) || rsp_q_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_en        <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         pending_count <= '0;
         rsp_err       <= 1'b0;
         rsp_q_valid   <= 1'b0;
      end else begin
         out_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         case ({rd_issue, rsp_deliver})
            2'b10:   pending_count <= pending_count + CW'(1);
            2'b01:   if (pending_count != '0) pending_count <= pending_count - CW'(1);
            default: pending_count <= pending_count;
         endcase

         // An unmatched response is still forwarded; only the sticky flag records it
         if (rsp_take && (pending_count == '0)) rsp_err <= 1'b1;

         if (rsp_take)         rsp_q_valid <= 1'b1;
         else if (rsp_deliver) rsp_q_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PW-2:0]] <= req_in;
      if (rsp_take) begin
         rsp_q_data <= mem_rsp_data;
         rsp_q_tag  <= mem_rsp_tag;
      end
   end

endmodule

// File: tb/tb_vx_core_mem_bridge.sv
// Scoreboard bench for vx_core_mem_bridge with a two-credit read limit.
module tb_vx_core_mem_bridge;

   localparam int DW = 64;
   localparam int AW = 26;
   localparam int TW = 8;
   localparam int BW = DW / 8;
   localparam int MP = 2;
   localparam int CW = $clog2(MP + 1);
   localparam int RQW = 1 + BW + AW + DW + TW;
   localparam int RSW = DW + TW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          core_req_valid = 1'b0;
   logic          core_req_rw = 1'b0;
   logic [BW-1:0] core_req_byteen = '0;
   logic [AW-1:0] core_req_addr = '0;
   logic [DW-1:0] core_req_data = '0;
   logic [TW-1:0] core_req_tag = '0;
   logic          core_req_ready;
   logic          core_rsp_valid;
   logic [DW-1:0] core_rsp_data;
   logic [TW-1:0] core_rsp_tag;
   logic          core_rsp_ready = 1'b1;
   logic          mem_req_valid;
   logic          mem_req_rw;
   logic [BW-1:0] mem_req_byteen;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_data;
   logic [TW-1:0] mem_req_tag;
   logic          mem_req_ready = 1'b0;
   logic          mem_rsp_valid = 1'b0;
   logic [DW-1:0] mem_rsp_data = '0;
   logic [TW-1:0] mem_rsp_tag = '0;
   logic          mem_rsp_ready;
   logic [CW-1:0] pending_count;
   logic          busy;
   logic          rsp_err;

   vx_core_mem_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .REQ_DEPTH(4), .MAX_PENDING(MP)
   ) dut (
      .clk(clk), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_byteen(core_req_byteen),
      .core_req_addr(core_req_addr), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
      .core_req_ready(core_req_ready),
      .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
      .core_rsp_ready(core_rsp_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
      .mem_rsp_ready(mem_rsp_ready),
      .pending_count(pending_count), .busy(busy), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_req_out = 0;
   int n_rsp_out = 0;
   int base;
   logic [RQW-1:0] exp_req[$];
   logic [RSW-1:0] exp_rsp[$];
   logic [RQW-1:0] req_e;
   logic [RSW-1:0] rsp_e;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] rsp_pat(input logic [TW-1:0] tag);
      return 64'hD00D_0000_0000_0000 | (64'(tag) * 64'h0001_0003_0007);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic rw, input logic [TW-1:0] tag);
      int w;
      core_req_valid  = 1'b1;
      core_req_rw     = rw;
      core_req_tag    = tag;
      core_req_addr   = AW'(32'(tag) * 7 + 100);
      core_req_data   = {32'hC0DE0000 | 32'(tag), 32'($urandom())};
      core_req_byteen = rw ? (tag ^ 8'h5A) : '1;
      w = 0;
      @(negedge clk);
      while (!core_req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!core_req_ready) chk("req_accept_timeout", 128'(core_req_ready), 128'(1));
      else exp_req.push_back({core_req_rw, core_req_byteen, core_req_addr, core_req_data, core_req_tag});
      @(posedge clk);
      #1;
      core_req_valid = 1'b0;
   endtask

   task automatic send_rsp(input logic [TW-1:0] tag);
      int w;
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = tag;
      mem_rsp_data  = rsp_pat(tag);
      w = 0;
      @(negedge clk);
      while (!mem_rsp_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!mem_rsp_ready) chk("rsp_accept_timeout", 128'(mem_rsp_ready), 128'(1));
      else exp_rsp.push_back({mem_rsp_data, mem_rsp_tag});
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
   endtask

   // Monitors observe handshakes mid-cycle, i.e. the transfer at the next rising edge
   always @(negedge clk) begin
      if (reset && mem_req_valid && mem_req_ready) begin
         n_req_out++;
         chk("mem_req_expected", 128'(exp_req.size() != 0), 128'(1));
         if (exp_req.size() != 0) begin
            req_e = exp_req.pop_front();
            chk("mem_req_payload",
                128'({mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag}), 128'(req_e));
         end
      end
      if (reset && core_rsp_valid && core_rsp_ready) begin
         n_rsp_out++;
         chk("core_rsp_expected", 128'(exp_rsp.size() != 0), 128'(1));
         if (exp_rsp.size() != 0) begin
            rsp_e = exp_rsp.pop_front();
            chk("core_rsp_payload", 128'({core_rsp_data, core_rsp_tag}), 128'(rsp_e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_core_req_ready", 128'(core_req_ready), 128'(0));
      chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
      chk("rst_core_rsp_valid", 128'(core_rsp_valid), 128'(0));
      chk("rst_mem_rsp_ready", 128'(mem_rsp_ready), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_pending", 128'(pending_count), 128'(0));
      chk("rst_err", 128'(rsp_err), 128'(0));
      reset = 1'b1;
      #1;
      chk("rel_ready_still_low", 128'(core_req_ready), 128'(0));
      tick();
      chk("rel_core_req_ready", 128'(core_req_ready), 128'(1));
      chk("rel_mem_rsp_ready", 128'(mem_rsp_ready), 128'(1));

      // Four writes fill the FIFO, then drain in order at one per cycle
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_req(1'b1, TW'(i + 10));
      chk("t1_full_ready", 128'(core_req_ready), 128'(0));
      chk("t1_valid", 128'(mem_req_valid), 128'(1));
      mem_req_ready = 1'b1;
      base = n_req_out;
      repeat (3) tick();
      chk("t1_busy_before_last", 128'(busy), 128'(1));
      tick();
      chk("t1_busy_after_last", 128'(busy), 128'(0));
      chk("t1_drained_count", 128'(n_req_out - base), 128'(4));
      chk("t1_ready_again", 128'(core_req_ready), 128'(1));

      // Credit limit: third read is held until a response returns
      base = n_req_out;
      send_req(1'b0, 8'd1);
      send_req(1'b0, 8'd2);
      send_req(1'b0, 8'd3);
      repeat (2) tick();
      chk("t2_pending_max", 128'(pending_count), 128'(2));
      chk("t2_read_held", 128'(mem_req_valid), 128'(0));
      chk("t2_issued", 128'(n_req_out - base), 128'(2));
      send_rsp(8'd1);
      chk("t2_rsp_latency_tag", 128'(core_rsp_tag), 128'(1));
      chk("t2_still_held", 128'(mem_req_valid), 128'(0));
      tick();
      chk("t2_pending_dec", 128'(pending_count), 128'(1));
      chk("t2_tag3_valid", 128'(mem_req_valid), 128'(1));
      chk("t2_tag3_tag", 128'(mem_req_tag), 128'(3));
      tick();
      chk("t2_pending_refill", 128'(pending_count), 128'(2));

      // Back-to-back responses; a decrement and an issue share one edge
      send_req(1'b0, 8'd4);
      send_rsp(8'd2);
      chk("t3_rsp_tag_latency", 128'(core_rsp_tag), 128'(2));
      chk("t3_rsp_data_latency", 128'(core_rsp_data), 128'(rsp_pat(8'd2)));
      send_rsp(8'd3);
      chk("t3_pending_after_dec", 128'(pending_count), 128'(1));
      chk("t3_read4_valid", 128'(mem_req_valid), 128'(1));
      tick();
      chk("t3_pending_unchanged", 128'(pending_count), 128'(1));
      chk("t3_queue_empty", 128'(mem_req_valid), 128'(0));
      send_rsp(8'd4);
      tick();
      chk("t3_pending_zero", 128'(pending_count), 128'(0));
      chk("t3_idle", 128'(busy), 128'(0));

      // Held response backpressures the memory side
      send_req(1'b0, 8'd5);
      send_req(1'b0, 8'd6);
      tick();
      chk("t4_pending", 128'(pending_count), 128'(2));
      core_rsp_ready = 1'b0;
      send_rsp(8'd5);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 8'd6;
      mem_rsp_data  = rsp_pat(8'd6);
      #1;
      chk("t4_mem_rsp_blocked", 128'(mem_rsp_ready), 128'(0));
      repeat (2) tick();
      chk("t4_still_blocked", 128'(mem_rsp_ready), 128'(0));
      chk("t4_first_held", 128'(core_rsp_tag), 128'(5));
      base = n_rsp_out;
      core_rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_mem_rsp_reopen", 128'(mem_rsp_ready), 128'(1));
      if (mem_rsp_ready) exp_rsp.push_back({mem_rsp_data, mem_rsp_tag});
      tick();
      mem_rsp_valid = 1'b0;
      chk("t4_second_tag", 128'(core_rsp_tag), 128'(6));
      tick();
      chk("t4_delivered", 128'(n_rsp_out - base), 128'(2));
      chk("t4_pending_zero", 128'(pending_count), 128'(0));
      chk("t4_no_err", 128'(rsp_err), 128'(0));

      // Unmatched response
      send_rsp(8'h77);
      chk("t5_err_set", 128'(rsp_err), 128'(1));
      chk("t5_pending_zero", 128'(pending_count), 128'(0));
      tick();
      chk("t5_no_underflow", 128'(pending_count), 128'(0));
      tick();
      chk("t5_err_sticky", 128'(rsp_err), 128'(1));
      chk("t5_idle", 128'(busy), 128'(0));

      // Reset mid-operation with queued writes and pending reads
      send_req(1'b0, 8'd8);
      send_req(1'b0, 8'd9);
      tick();
      chk("t6_pending", 128'(pending_count), 128'(2));
      mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_req(1'b1, TW'(i + 20));
      chk("t6_write_not_throttled", 128'(mem_req_valid), 128'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("t6_req_ready_low", 128'(core_req_ready), 128'(0));
      chk("t6_mem_req_valid_low", 128'(mem_req_valid), 128'(0));
      chk("t6_core_rsp_valid_low", 128'(core_rsp_valid), 128'(0));
      chk("t6_mem_rsp_ready_low", 128'(mem_rsp_ready), 128'(0));
      chk("t6_busy_low", 128'(busy), 128'(0));
      chk("t6_pending_cleared", 128'(pending_count), 128'(0));
      chk("t6_err_cleared", 128'(rsp_err), 128'(0));
      exp_req.delete();
      exp_rsp.delete();
      #3;
      reset = 1'b1;
      tick();
      chk("t6_ready_back", 128'(core_req_ready), 128'(1));
      chk("t6_queue_empty", 128'(mem_req_valid), 128'(0));
      mem_req_ready = 1'b1;
      base = n_req_out;
      repeat (2) tick();
      chk("t6_nothing_issued", 128'(n_req_out - base), 128'(0));
      chk("t6_idle", 128'(busy), 128'(0));

      chk("end_req_scoreboard_empty", 128'(exp_req.size()), 128'(0));
      chk("end_rsp_scoreboard_empty", 128'(exp_rsp.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
